// File: rtl/i2s_to_wb_pkg.sv
// ----------------------------------------------------------------------------
// Module      : i2s_to_wb_pkg
// Description : Shared FSM state type and bus constants for the I2S-to-Wishbone
//               transmit DMA.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

package i2s_to_wb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUS   = 2'd1,
    ST_HOLD  = 2'd2,
    ST_ERROR = 2'd3
  } dma_state_e;

  localparam int unsigned WORD_BYTES = 4;
  localparam logic [3:0]  WB_SEL_ALL = 4'b1111;

endpackage

`default_nettype wire

// File: rtl/i2s_to_wb_fifo_fwft.sv
// ----------------------------------------------------------------------------
// Module      : i2s_to_wb_fifo_fwft
// Description : First-word-fall-through FIFO, power-of-two depth, synchronous
//               flush, occupancy count output.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module i2s_to_wb_fifo_fwft #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       wr_data_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       rd_data_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW:0]      count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    do_pop   = pop_i && (count_q != '0) && !flush_i;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    do_push  = push_i && !flush_i && ((count_q != (PW+1)'(DEPTH)) || do_pop);
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      if (do_push) mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;

endmodule

`default_nettype wire

// File: rtl/i2s_to_wb_tx_dma_ring.sv
// ----------------------------------------------------------------------------
// Module      : i2s_to_wb_tx_dma_ring
// Description : Ring-buffer Wishbone read DMA feeding the I2S transmit FIFO.
//               Define I2S_TO_WB_DMA_BUF_IRQ_EN for half/wrap event outputs.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module i2s_to_wb_tx_dma_ring
  import i2s_to_wb_pkg::*;
#(
  parameter int DMA_BUFFER_MAX_WIDTH = 12,
  parameter int FIFO_DEPTH           = 8,
  parameter int RTY_MAX              = 7
) (
  input  logic                            i2s_clk_i,
  input  logic                            i2s_rst_i,
  input  logic                            i2s_enable,
  output logic [31:0]                     wbm_addr_o,
  output logic [3:0]                      wbm_sel_o,
  output logic                            wbm_we_o,
  output logic                            wbm_cyc_o,
  output logic                            wbm_stb_o,
  input  logic [31:0]                     wbm_data_i,
  input  logic                            wbm_ack_i,
  input  logic                            wbm_err_i,
  input  logic                            wbm_rty_i,
  input  logic                            fifo_pop,
  output logic [31:0]                     fifo_data_o,
  output logic                            fifo_empty,
  input  logic [31:0]                     dma_base_i,
  input  logic                            dma_base_we,
  input  logic [DMA_BUFFER_MAX_WIDTH-1:0] dma_buffer_size,
  output logic [31:0]                     dma_rd_pointer_o,
`ifdef I2S_TO_WB_DMA_BUF_IRQ_EN
  output logic                            dma_half_o,
  output logic                            dma_wrap_o,
`endif
  output logic                            dma_underrun_o,
  output logic                            dma_bus_error_o,
  input  logic                            dma_status_clr
);

  localparam int         AW   = DMA_BUFFER_MAX_WIDTH;
  localparam int         CW   = $clog2(FIFO_DEPTH) + 1;
  localparam int         RW   = (RTY_MAX < 1) ? 1 : $clog2(RTY_MAX + 1);
  localparam logic [AW:0] STEP = (AW+1)'(WORD_BYTES);

  dma_state_e    state_q, state_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   base_q, base_d;
  logic [AW-1:0] offset_q, offset_d;
  logic [RW-1:0] rty_cnt_q, rty_cnt_d;
  logic          stale_q, stale_d;
  logic          underrun_q, underrun_d;
  logic          bus_err_q, bus_err_d;

  logic [31:0]   new_base, rd_pointer;
  logic [AW:0]   offset_inc;
  logic          offset_wrap;
  logic [AW-1:0] offset_next;
  logic          fifo_push, fifo_flush, bus_fault, acked;
  logic [CW-1:0] fifo_count;
  logic          unused_base_lsb;

  assign unused_base_lsb = ^dma_base_i[1:0];
  assign new_base        = {dma_base_i[31:2], 2'b00};
  assign rd_pointer      = base_q + 32'(offset_q);

  always_comb begin
    offset_inc  = {1'b0, offset_q} + STEP;
    offset_wrap = (offset_inc >= {1'b0, dma_buffer_size});
    offset_next = offset_wrap ? '0 : offset_inc[AW-1:0];
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    base_d     = base_q;
    offset_d   = offset_q;
    rty_cnt_d  = rty_cnt_q;
    fifo_push  = 1'b0;
    fifo_flush = 1'b0;
    bus_fault  = 1'b0;
    acked      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!i2s_enable) begin
          fifo_flush = 1'b1;
        end else if (fifo_count < CW'(FIFO_DEPTH)) begin
          state_d = ST_BUS;
          addr_d  = dma_base_we ? new_base : rd_pointer;
        end
      end
      ST_BUS: begin
        if (wbm_err_i || (wbm_rty_i && (rty_cnt_q == RW'(RTY_MAX)))) begin
          bus_fault = 1'b1;
          rty_cnt_d = '0;
          state_d   = ST_ERROR;
        end else if (wbm_ack_i) begin
          fifo_push = 1'b1;
          acked     = 1'b1;
          rty_cnt_d = '0;
          state_d   = ST_IDLE;
        end else if (wbm_rty_i) begin
          rty_cnt_d = rty_cnt_q + 1'b1;
          state_d   = ST_HOLD;
        end
      end
      ST_HOLD:  state_d = ST_BUS;
      ST_ERROR: if (dma_status_clr || !i2s_enable) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    // A transfer in flight across a base reload must not advance the new ring.
    if (dma_base_we) begin
      base_d   = new_base;
      offset_d = '0;
    end else if (acked && !stale_q) begin
      offset_d = offset_next;
    end
    stale_d = ((state_d == ST_BUS) || (state_d == ST_HOLD)) &&
              (stale_q || (dma_base_we && (state_q != ST_IDLE)));

    underrun_d = (underrun_q && !dma_status_clr) || (fifo_pop && fifo_empty);
    bus_err_d  = (bus_err_q && !dma_status_clr) || bus_fault;
  end

  always_ff @(posedge i2s_clk_i or negedge i2s_rst_i) begin
    if (!i2s_rst_i) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      base_q     <= '0;
      offset_q   <= '0;
      rty_cnt_q  <= '0;
      stale_q    <= 1'b0;
      underrun_q <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      base_q     <= base_d;
      offset_q   <= offset_d;
      rty_cnt_q  <= rty_cnt_d;
      stale_q    <= stale_d;
      underrun_q <= underrun_d;
      bus_err_q  <= bus_err_d;
    end
  end

`ifdef I2S_TO_WB_DMA_BUF_IRQ_EN
  logic        half_q, half_d;
  logic        wrap_q, wrap_d;
  logic [AW:0] half_off;

  always_comb begin
    half_off = ({1'b0, dma_buffer_size} >> 1) - STEP;
    half_d   = acked && !stale_q && ({1'b0, offset_q} == half_off);
    wrap_d   = acked && !stale_q && offset_wrap;
  end

  always_ff @(posedge i2s_clk_i or negedge i2s_rst_i) begin
    if (!i2s_rst_i) begin
      half_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      half_q <= half_d;
      wrap_q <= wrap_d;
    end
  end

  assign dma_half_o = half_q;
  assign dma_wrap_o = wrap_q;
`endif

  i2s_to_wb_fifo_fwft #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk       (i2s_clk_i),
    .rst_n     (i2s_rst_i),
    .flush_i   (fifo_flush),
    .push_i    (fifo_push),
    .wr_data_i (wbm_data_i),
    .pop_i     (fifo_pop),
    .rd_data_o (fifo_data_o),
    .empty_o   (fifo_empty),
    .count_o   (fifo_count)
  );

  assign wbm_addr_o       = addr_q;
  assign wbm_sel_o        = WB_SEL_ALL;
  assign wbm_we_o         = 1'b0;
  assign wbm_cyc_o        = (state_q == ST_BUS);
  assign wbm_stb_o        = (state_q == ST_BUS);
  assign dma_rd_pointer_o = rd_pointer;
  assign dma_underrun_o   = underrun_q;
  assign dma_bus_error_o  = bus_err_q;

endmodule

`default_nettype wire

// File: tb/tb_i2s_to_wb_tx_dma_ring.sv
// ----------------------------------------------------------------------------
// Module      : tb_i2s_to_wb_tx_dma_ring
// Description : Self-checking bench for the ring TX DMA with a scripted
//               Wishbone slave and a FIFO data scoreboard.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module tb_i2s_to_wb_tx_dma_ring;

  localparam int AW     = 12;
  localparam int R_ACK  = 0;
  localparam int R_RTY  = 1;
  localparam int R_ERR  = 2;
  localparam int R_WAIT = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic [31:0]   wbm_addr;
  logic [3:0]    wbm_sel;
  logic          wbm_we, wbm_cyc, wbm_stb;
  logic [31:0]   wbm_data = '0;
  logic          wbm_ack = 1'b0, wbm_err = 1'b0, wbm_rty = 1'b0;
  logic          fifo_pop = 1'b0;
  logic [31:0]   fifo_data;
  logic          fifo_empty;
  logic [31:0]   dma_base = '0;
  logic          dma_base_we = 1'b0;
  logic [AW-1:0] dma_size = 12'd16;
  logic [31:0]   rd_ptr;
  logic          underrun, bus_error;
  logic          status_clr = 1'b0;
`ifdef I2S_TO_WB_DMA_BUF_IRQ_EN
  logic          half_ev, wrap_ev;
  int            half_cnt = 0, wrap_cnt = 0;
`endif

  int            checks = 0, errors = 0, cycle = 0;
  logic [31:0]   sb_q[$];
  logic [31:0]   log_addr[$];
  int            log_time[$];
  int            resp_q[$];
  int            resp_default = R_ACK;
  logic          prev_cyc = 1'b0;

  i2s_to_wb_tx_dma_ring dut (
    .i2s_clk_i        (clk),
    .i2s_rst_i        (rst_n),
    .i2s_enable       (enable),
    .wbm_addr_o       (wbm_addr),
    .wbm_sel_o        (wbm_sel),
    .wbm_we_o         (wbm_we),
    .wbm_cyc_o        (wbm_cyc),
    .wbm_stb_o        (wbm_stb),
    .wbm_data_i       (wbm_data),
    .wbm_ack_i        (wbm_ack),
    .wbm_err_i        (wbm_err),
    .wbm_rty_i        (wbm_rty),
    .fifo_pop         (fifo_pop),
    .fifo_data_o      (fifo_data),
    .fifo_empty       (fifo_empty),
    .dma_base_i       (dma_base),
    .dma_base_we      (dma_base_we),
    .dma_buffer_size  (dma_size),
    .dma_rd_pointer_o (rd_ptr),
`ifdef I2S_TO_WB_DMA_BUF_IRQ_EN
    .dma_half_o       (half_ev),
    .dma_wrap_o       (wrap_ev),
`endif
    .dma_underrun_o   (underrun),
    .dma_bus_error_o  (bus_error),
    .dma_status_clr   (status_clr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  // Scripted zero-wait slave: one response per cycle while cyc is high.
  initial begin
    forever begin
      @(negedge clk);
      wbm_ack = 1'b0;
      wbm_rty = 1'b0;
      wbm_err = 1'b0;
      if (wbm_cyc) begin
        int r;
        if (!prev_cyc) begin
          log_addr.push_back(wbm_addr);
          log_time.push_back(cycle);
        end
        r = (resp_q.size() > 0) ? resp_q.pop_front() : resp_default;
        case (r)
          R_ACK: begin
            wbm_data = mem_word(wbm_addr);
            wbm_ack  = 1'b1;
            sb_q.push_back(wbm_data);
          end
          R_RTY:   wbm_rty = 1'b1;
          R_ERR:   wbm_err = 1'b1;
          default: ;
        endcase
      end
      prev_cyc = wbm_cyc;
    end
  end

`ifdef I2S_TO_WB_DMA_BUF_IRQ_EN
  initial begin
    forever begin
      @(negedge clk);
      if (half_ev) half_cnt++;
      if (wrap_ev) wrap_cnt++;
    end
  end
`endif

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic wait_log(input int n, input int budget, input string name);
    int k;
    k = 0;
    while (log_addr.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (log_addr.size() < n) begin
      errors++;
      $display("FAIL %s: timeout with %0d bus cycles, expected %0d", name, log_addr.size(), n);
    end
  endtask

  task automatic pop_check(input string name);
    logic [31:0] e;
    check({name, "_nonempty"}, {31'b0, fifo_empty}, 32'd0);
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty, got 0x%08h, expected none", name, fifo_data);
    end else begin
      e = sb_q.pop_front();
      checks--;
      check(name, fifo_data, e);
    end
    fifo_pop = 1'b1;
    @(negedge clk);
    fifo_pop = 1'b0;
  endtask

  task automatic quiesce();
    resp_default = R_ACK;
    enable       = 1'b0;
    fifo_pop     = 1'b0;
    repeat (6) @(negedge clk);
    resp_q.delete();
    sb_q.delete();
    log_addr.delete();
    log_time.delete();
`ifdef I2S_TO_WB_DMA_BUF_IRQ_EN
    half_cnt = 0;
    wrap_cnt = 0;
`endif
  endtask

  task automatic load_ring(input logic [AW-1:0] s, input logic [31:0] b);
    dma_size    = s;
    dma_base    = b;
    dma_base_we = 1'b1;
    @(negedge clk);
    dma_base_we = 1'b0;
  endtask

  typedef struct {
    logic [AW-1:0] ring_size;
    logic [31:0]   base;
    logic [31:0]   exp_last;
    logic [31:0]   exp_ptr;
  } ring_vec_t;

  ring_vec_t vecs[5];

  initial begin
    logic [31:0] base_al, exp_a;
    int          off, eh, ew;

    vecs[0] = '{12'd16,   32'h0000_1000, 32'h0000_100C, 32'h0000_1000};
    vecs[1] = '{12'd24,   32'h0000_2003, 32'h0000_2004, 32'h0000_2008};
    vecs[2] = '{12'd8,    32'h0000_FFF8, 32'h0000_FFFC, 32'h0000_FFF8};
    vecs[3] = '{12'd4088, 32'h8000_0000, 32'h8000_001C, 32'h8000_0020};
    vecs[4] = '{12'd40,   32'hFFFF_FFF0, 32'h0000_000C, 32'h0000_0010};

    repeat (3) @(negedge clk);
    check("rst_cyc",      {31'b0, wbm_cyc},    32'd0);
    check("rst_stb",      {31'b0, wbm_stb},    32'd0);
    check("rst_we",       {31'b0, wbm_we},     32'd0);
    check("rst_sel",      {28'b0, wbm_sel},    32'hF);
    check("rst_addr",     wbm_addr,            32'd0);
    check("rst_empty",    {31'b0, fifo_empty}, 32'd1);
    check("rst_data",     fifo_data,           32'd0);
    check("rst_ptr",      rd_ptr,              32'd0);
    check("rst_underrun", {31'b0, underrun},   32'd0);
    check("rst_buserr",   {31'b0, bus_error},  32'd0);
`ifdef I2S_TO_WB_DMA_BUF_IRQ_EN
    check("rst_half",     {31'b0, half_ev},    32'd0);
    check("rst_wrap",     {31'b0, wrap_ev},    32'd0);
`endif
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Ring fill: zero-wait acks, no pops until the FIFO is full.
    for (int v = 0; v < 5; v++) begin
      quiesce();
      load_ring(vecs[v].ring_size, vecs[v].base);
      base_al = {vecs[v].base[31:2], 2'b00};
      enable  = 1'b1;
      wait_log(8, 100, "fill");
      repeat (10) @(negedge clk);
      check("fill_count", log_addr.size(), 32'd8);
      check("full_no_cyc", {31'b0, wbm_cyc}, 32'd0);
      eh = 0;
      ew = 0;
      for (int k = 0; k < 8; k++) begin
        off   = (4 * k) % int'(vecs[v].ring_size);
        exp_a = base_al + 32'(off);
        check("ring_addr", log_addr[k], exp_a);
        if (off == int'(vecs[v].ring_size) / 2 - 4) eh++;
        if (off == int'(vecs[v].ring_size) - 4) ew++;
      end
      check("ring_last", log_addr[7], vecs[v].exp_last);
      check("ring_ptr", rd_ptr, vecs[v].exp_ptr);
      check("throughput", log_time[7] - log_time[0], 32'd14);
`ifdef I2S_TO_WB_DMA_BUF_IRQ_EN
      check("half_events", half_cnt, eh);
      check("wrap_events", wrap_cnt, ew);
`endif
      pop_check("data_pop1");
      repeat (10) @(negedge clk);
      check("refill_count", log_addr.size(), 32'd9);
      off = 32 % int'(vecs[v].ring_size);
      check("refill_addr", log_addr[8], base_al + 32'(off));
      for (int k = 0; k < 8; k++) pop_check("data_drain");
    end

    // Two retries then ack: same address, one idle cycle between attempts.
    quiesce();
    load_ring(12'd16, 32'h2000);
    resp_q = '{R_RTY, R_RTY};
    enable = 1'b1;
    wait_log(10, 200, "retry_fill");
    repeat (10) @(negedge clk);
    check("retry_cycles", log_addr.size(), 32'd10);
    for (int k = 0; k < 3; k++) check("retry_addr", log_addr[k], 32'h2000);
    check("retry_next_addr", log_addr[3], 32'h2004);
    for (int k = 0; k < 3; k++) check("retry_gap", log_time[k+1] - log_time[k], 32'd2);
    check("retry_no_err", {31'b0, bus_error}, 32'd0);
    for (int k = 0; k < 8; k++) pop_check("retry_data");

    // RTY_MAX+1 consecutive retries become a bus error.
    quiesce();
    load_ring(12'd16, 32'h2100);
    for (int k = 0; k < 8; k++) resp_q.push_back(R_RTY);
    enable = 1'b1;
    wait_log(8, 200, "rtylim_cycles");
    repeat (20) @(negedge clk);
    check("rtylim_err", {31'b0, bus_error}, 32'd1);
    check("rtylim_stop", log_addr.size(), 32'd8);
    check("rtylim_cyc", {31'b0, wbm_cyc}, 32'd0);
    check("rtylim_empty", {31'b0, fifo_empty}, 32'd1);
    check("rtylim_ptr", rd_ptr, 32'h2100);
    for (int k = 0; k < 8; k++) check("rtylim_addr", log_addr[k], 32'h2100);
    status_clr = 1'b1;
    @(negedge clk);
    status_clr = 1'b0;
    check("rtylim_clr", {31'b0, bus_error}, 32'd0);
    wait_log(9, 50, "rtylim_resume");
    check("rtylim_resume_addr", log_addr[8], 32'h2100);
    repeat (4) @(negedge clk);
    pop_check("rtylim_data");

    // Underrun is sticky; a set in the same cycle as clear wins.
    quiesce();
    check("udr_idle", {31'b0, underrun}, 32'd0);
    fifo_pop = 1'b1;
    @(negedge clk);
    fifo_pop = 1'b0;
    check("udr_set", {31'b0, underrun}, 32'd1);
    repeat (5) @(negedge clk);
    check("udr_sticky", {31'b0, underrun}, 32'd1);
    check("udr_empty", {31'b0, fifo_empty}, 32'd1);
    status_clr = 1'b1;
    @(negedge clk);
    status_clr = 1'b0;
    check("udr_clr", {31'b0, underrun}, 32'd0);
    fifo_pop   = 1'b1;
    status_clr = 1'b1;
    @(negedge clk);
    fifo_pop   = 1'b0;
    status_clr = 1'b0;
    check("udr_set_wins", {31'b0, underrun}, 32'd1);
    status_clr = 1'b1;
    @(negedge clk);
    status_clr = 1'b0;

    // Base reload while a read of 0x1008 is pending.
    quiesce();
    load_ring(12'd16, 32'h1000);
    resp_q       = '{R_ACK, R_ACK};
    resp_default = R_WAIT;
    enable       = 1'b1;
    wait_log(3, 50, "reload_pending");
    repeat (3) @(negedge clk);
    check("reload_busy", {31'b0, wbm_cyc}, 32'd1);
    check("reload_old_addr", wbm_addr, 32'h1008);
    dma_base    = 32'h3000;
    dma_base_we = 1'b1;
    @(negedge clk);
    dma_base_we = 1'b0;
    check("reload_ptr", rd_ptr, 32'h3000);
    check("reload_keep_addr", wbm_addr, 32'h1008);
    repeat (2) @(negedge clk);
    resp_default = R_ACK;
    wait_log(5, 50, "reload_next");
    check("reload_log2", log_addr[2], 32'h1008);
    check("reload_log3", log_addr[3], 32'h3000);
    check("reload_log4", log_addr[4], 32'h3004);
    for (int k = 0; k < 4; k++) pop_check("reload_data");

    // Asynchronous reset in the middle of a bus cycle.
    quiesce();
    load_ring(12'd16, 32'h1000);
    resp_q       = '{R_ACK, R_ACK};
    resp_default = R_WAIT;
    enable       = 1'b1;
    wait_log(3, 50, "rst_pending");
    @(negedge clk);
    check("midrst_busy", {31'b0, wbm_cyc}, 32'd1);
    check("midrst_words", {31'b0, fifo_empty}, 32'd0);
    rst_n = 1'b0;
    #1;
    check("midrst_cyc", {31'b0, wbm_cyc}, 32'd0);
    check("midrst_empty", {31'b0, fifo_empty}, 32'd1);
    check("midrst_ptr", rd_ptr, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    quiesce();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
